// File: rtl/muldiv_unit.sv
// Iterative 32-bit unsigned multiply / divide unit: one bit per cycle.
// Define MULDIV_REM_EN to enable REMU (op 10); otherwise op 10 returns 0 like op 11.
module muldiv_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [1:0]  req_op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic        resp_zero
);

  localparam int DATA_W = 32;

  localparam logic [1:0] OP_MUL  = 2'b00;
  localparam logic [1:0] OP_DIVU = 2'b01;
`ifdef MULDIV_REM_EN
  localparam logic [1:0] OP_REMU = 2'b10;
`endif

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t                   state_q, state_d;
  logic [4:0]               cnt_q, cnt_d;
  logic [1:0]               op_q, op_d;
  logic signed [DATA_W-1:0] result_q, result_d;
  logic [DATA_W-1:0]        a_q, a_d;
  logic [DATA_W-1:0]        b_q, b_d;
  logic [DATA_W-1:0]        acc_q, acc_d;
  logic [DATA_W:0]          trial;

  // MSB-first shift-add; only the low DATA_W bits of the product survive.
  function automatic logic [DATA_W-1:0] mul_step(input logic [DATA_W-1:0] acc,
                                                 input logic [DATA_W-1:0] mcand,
                                                 input logic              mbit);
    mul_step = {acc[DATA_W-2:0], 1'b0} + (mbit ? mcand : '0);
  endfunction

  assign req_ready   = (state_q == IDLE);
  assign resp_valid  = (state_q == DONE);
  assign resp_result = result_q;
  assign resp_zero   = (result_q == '0);

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    a_d      = a_q;
    b_d      = b_q;
    acc_d    = acc_q;
    result_d = result_q;
    // Restoring trial: partial remainder shifted with next dividend bit, minus divisor.
    trial    = {acc_q, a_q[DATA_W-1]} - {1'b0, b_q};

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          op_d    = req_op;
          a_d     = operand_a;
          b_d     = operand_b;
          acc_d   = '0;
          cnt_d   = 5'd31;
          state_d = BUSY;
          case (req_op)
            OP_MUL: ;
            OP_DIVU: begin
              if (operand_b == '0) begin
                state_d  = DONE;
                result_d = '0;
              end
            end
`ifdef MULDIV_REM_EN
            OP_REMU: begin
              if (operand_b == '0) begin
                state_d  = DONE;
                result_d = operand_a;
              end
            end
`endif
            default: begin
              state_d  = DONE;
              result_d = '0;
            end
          endcase
        end
      end

      BUSY: begin
        if (op_q == OP_MUL) begin
          acc_d = mul_step(acc_q, a_q, b_q[DATA_W-1]);
          b_d   = {b_q[DATA_W-2:0], 1'b0};
        end else if (!trial[DATA_W]) begin
          acc_d = trial[DATA_W-1:0];
          a_d   = {a_q[DATA_W-2:0], 1'b1};
        end else begin
          acc_d = {acc_q[DATA_W-2:0], a_q[DATA_W-1]};
          a_d   = {a_q[DATA_W-2:0], 1'b0};
        end
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd0) begin
          state_d = DONE;
          if (op_q == OP_MUL) result_d = acc_d;
`ifdef MULDIV_REM_EN
          else if (op_q == OP_REMU) result_d = acc_d;
`endif
          else result_d = a_d;
        end
      end

      DONE: begin
        if (resp_ready) state_d = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  // Control state and the visible result register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  // Datapath operands and accumulator
  always_ff @(posedge clk) begin
    op_q  <= op_d;
    a_q   <= a_d;
    b_q   <= b_d;
    acc_q <= acc_d;
  end

endmodule

// File: doc/muldiv_unit.md
MULDIV_UNIT -- requirements
Module: muldiv_unit

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: rst_n  input  1  reset; asynchronous, active-low.
REQ-003 SHALL have port: req_valid  input  1  core presents an operation.
REQ-004 SHALL have port: req_ready  output  1  unit can accept an operation.
REQ-005 SHALL have port: req_op  input  2  00 MUL (low 32 bits), 01 DIVU, 10 REMU, 11 reserved.
REQ-006 SHALL have port: operand_a  input  32  dividend or multiplicand.
REQ-007 SHALL have port: operand_b  input  32  divisor or multiplier.
REQ-008 SHALL have port: resp_valid  output  1  result available.
REQ-009 SHALL have port: resp_ready  input  1  core consumes the result.
REQ-010 SHALL have port: resp_result  output  32  result word.
REQ-011 SHALL have port: resp_zero  output  1  high when resp_result == 0.

Function
REQ-012 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-013 SHALL assert req_ready only in IDLE; acceptance = req_valid && req_ready at a rising edge.
REQ-014 SHALL latch req_op and both operands on acceptance; later input changes have no effect.
REQ-015 SHALL move IDLE->BUSY on acceptance, load 5-bit counter with 31, and clear the accumulator or remainder.
REQ-016 SHALL process one bit per BUSY cycle: shift-add for MUL, restoring shift-subtract for DIVU/REMU, all unsigned.
REQ-017 SHALL leave BUSY->DONE on the cycle the counter is 0; BUSY lasts exactly 32 cycles, so resp_valid rises 33 edges after acceptance.
REQ-018 SHALL, for MUL, return bits [31:0] of the 64-bit product; overflow bits are discarded.
REQ-019 SHALL, for DIVU with operand_b == 0, skip BUSY, go IDLE->DONE, and return 0 (resp_valid 1 edge after acceptance).
REQ-020 SHALL, for op 11, skip BUSY and return 0 after 1 edge.
REQ-021 SHALL hold resp_valid, resp_result and resp_zero stable in DONE until resp_valid && resp_ready, then go to IDLE.
REQ-022 SHALL not accept a new request on the edge a response is consumed; req_ready rises the following cycle.
REQ-023 SHALL drive resp_zero combinationally from resp_result.

Reset
REQ-024 SHALL, on rst_n low at any time including mid-BUSY, go to IDLE asynchronously and abort any operation without a response.
REQ-025 SHALL reset outputs to: req_ready 1 after reset deasserts, resp_valid 0, resp_result 0, resp_zero 1.

Configuration
REQ-026 SHALL use macro MULDIV_REM_EN to select the remainder feature.
REQ-027 SHALL, with MULDIV_REM_EN defined, run op 10 as a 32-cycle REMU; REMU with operand_b == 0 returns operand_a after 1 edge.
REQ-028 SHALL, without MULDIV_REM_EN, treat op 10 like op 11 (result 0, 1-edge latency) and exclude remainder-output logic.

Verification
REQ-029 SHALL cover MUL 7 x 6: resp_result 42, resp_zero 0, resp_valid 33 edges after acceptance.
REQ-030 SHALL cover MUL 0x10000 x 0x10000: resp_result 0, resp_zero 1 (truncation).
REQ-031 SHALL cover DIVU 100 / 7: result 14; with MULDIV_REM_EN, REMU 100 % 7: result 2; without it, REMU result 0 after 1 edge.
REQ-032 SHALL cover DIVU 5 / 0: result 0, resp_zero 1, resp_valid 1 edge after acceptance.
REQ-033 SHALL cover resp_ready low for 10 cycles in DONE: result held stable and req_ready 0 throughout; req_ready 1 the cycle after consumption.
REQ-034 SHALL cover rst_n pulsed low at BUSY cycle 15: immediate IDLE, resp_valid 0, no response; next MUL 3 x 3 returns 9.
